paddle_ctrl: RTL

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/paddle_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/paddle_ctrl.sv
// Rotary-encoder paddle controller: accelerating detent steps are accumulated
// between frames and applied to the paddle position once per frame_tick.
module paddle_ctrl #(
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_H     = 64,
    parameter int STEP_MIN     = 2,
    parameter int ACCEL_WINDOW = 2700000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cw,
    input  logic       ccw,
    input  logic       frame_tick,
    input  logic       center,
    output logic [9:0] paddle_y,
    output logic       moving
);

    localparam int YMAX = SCREEN_H - PADDLE_H;
    localparam int YCTR = YMAX / 2;
    localparam int TW   = $clog2(ACCEL_WINDOW + 1);

    localparam logic [9:0]         YMAX_V  = 10'(YMAX);
    localparam logic [9:0]         YCTR_V  = 10'(YCTR);
    localparam logic [TW-1:0]      TMR_MAX = TW'(ACCEL_WINDOW);
    localparam logic signed [12:0] P_MAX   = 13'sd1023;
    localparam logic signed [12:0] P_MIN   = -13'sd1024;

    // A +detent moves the paddle towards larger line numbers (down the screen).
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    dir_t               dir_r;
    logic [1:0]         lvl_r;
    logic [TW-1:0]      tmr_r;
    logic signed [11:0] pend_r;

    logic               det_pos_s;
    logic               det_neg_s;
    logic               det_s;
    dir_t               det_dir_s;
    logic               same_s;
    logic [1:0]         lvl_new_s;
    logic [11:0]        step_s;
    logic signed [12:0] step_ext_s;
    logic signed [12:0] base_ext_s;
    logic signed [12:0] pend_sum_s;
    logic signed [11:0] pend_next_s;
    logic signed [12:0] y_sum_s;
    logic [9:0]         y_next_s;

    // Detent decode, speed level and saturating pending accumulation.
    always_comb begin
        det_pos_s  = cw & ~ccw;
        det_neg_s  = ccw & ~cw;
        det_s      = det_pos_s | det_neg_s;
        det_dir_s  = det_pos_s ? DIR_DOWN : DIR_UP;
        same_s     = det_s && (dir_r == det_dir_s) && (tmr_r < TMR_MAX);
        if (same_s) begin
            lvl_new_s = (lvl_r == 2'd3) ? 2'd3 : lvl_r + 2'd1;
        end else begin
            lvl_new_s = 2'd0;
        end
        step_s     = 12'(STEP_MIN) * ({10'd0, lvl_new_s} + 12'd1);
        step_ext_s = $signed({1'b0, step_s});
        // On a frame the old pending is consumed, so a coincident detent starts afresh.
        base_ext_s = frame_tick ? 13'sd0 : {pend_r[11], pend_r};
        if (det_pos_s) begin
            pend_sum_s = base_ext_s + step_ext_s;
        end else if (det_neg_s) begin
            pend_sum_s = base_ext_s - step_ext_s;
        end else begin
            pend_sum_s = base_ext_s;
        end
        if (pend_sum_s > P_MAX) begin
            pend_next_s = 12'sd1023;
        end else if (pend_sum_s < P_MIN) begin
            pend_next_s = -12'sd1024;
        end else begin
            pend_next_s = pend_sum_s[11:0];
        end
    end

    // Candidate paddle position for this frame, clamped to the playfield.
    always_comb begin
        y_sum_s = $signed({3'b000, paddle_y}) + {pend_r[11], pend_r};
        if (y_sum_s < 13'sd0) begin
            y_next_s = 10'd0;
        end else if (y_sum_s > $signed({3'b000, YMAX_V})) begin
            y_next_s = YMAX_V;
        end else begin
            y_next_s = y_sum_s[9:0];
        end
    end

    // State and output registers; center overrides frame and detent activity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            paddle_y <= YCTR_V;
            moving   <= 1'b0;
            pend_r   <= 12'sd0;
            lvl_r    <= 2'd0;
            dir_r    <= DIR_NONE;
            tmr_r    <= TMR_MAX;
        end else if (center) begin
            paddle_y <= YCTR_V;
            moving   <= 1'b0;
            pend_r   <= 12'sd0;
            lvl_r    <= 2'd0;
            dir_r    <= DIR_NONE;
            tmr_r    <= TMR_MAX;
        end else begin
            if (frame_tick) begin
                paddle_y <= y_next_s;
                moving   <= (pend_r != 12'sd0);
            end
            pend_r <= pend_next_s;
            if (det_s) begin
                dir_r <= det_dir_s;
                lvl_r <= lvl_new_s;
                tmr_r <= {TW{1'b0}};
            end else if (tmr_r < TMR_MAX) begin
                tmr_r <= tmr_r + TW'(1);
            end else begin
                dir_r <= DIR_NONE;
                lvl_r <= 2'd0;
            end
        end
    end

endmodule
